// File: rtl/mmio_periph_pkg.sv
// Shared definitions for the MEM-stage peripheral block.
// Covers the window base, the register offsets and the TCON bit positions.
package mmio_periph_pkg;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_DIGI    = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;
    localparam int TCON_W  = 3;
endpackage

// File: rtl/mmio_periph_if.sv
// Load/store bus between the EX/MEM outputs and the peripheral block.
interface mmio_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwr;
    logic        memread;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, wdata, memwr, memread, input rdata, hit);
    modport slave  (input addr, wdata, memwr, memread, output rdata, hit);
endinterface

// File: rtl/mmio_periph_timer.sv
// Reloading up-counter with a sticky interrupt status bit.
// It counts through 0xFFFF_FFFF and then reloads TL from TH.
module mmio_periph_timer
    import mmio_periph_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_th,
    input  logic              wr_tl,
    input  logic              wr_tcon,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);
    logic ovf;
    logic is_set;

    assign ovf    = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign is_set = ovf && tcon[TCON_IE];
    assign irq    = tcon[TCON_IE] & tcon[TCON_IS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     th <= '0;
        else if (wr_th) th <= wdata;
    end

    // A software write beats the count. A reload samples TH before any same-edge TH write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              tl <= '0;
        else if (wr_tl)          tl <= wdata;
        else if (ovf)            tl <= th;
        else if (tcon[TCON_EN])  tl <= tl + 32'd1;
    end

    // A hardware status set wins over a same-edge software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon[TCON_EN] <= wdata[TCON_EN];
            tcon[TCON_IE] <= wdata[TCON_IE];
            tcon[TCON_IS] <= wdata[TCON_IS] | is_set;
        end else if (is_set) begin
            tcon[TCON_IS] <= 1'b1;
        end
    end
endmodule

// File: rtl/mmio_periph.sv
// Peripheral window decoder. It holds the LED, DIGI and SYSTICK registers and the timer.
// Read data is combinational so that MEM can select it in the same cycle.
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          LED_W     = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    mmio_periph_if.slave      bus,
    output logic [LED_W-1:0]  leds,
    output logic [DIGI_W-1:0] digi,
    output logic              irq
);
    logic              in_win;
    logic [4:0]        off;
    logic              wr_en;
    logic [31:0]       systick;
    logic [31:0]       th;
    logic [31:0]       tl;
    logic [TCON_W-1:0] tcon;
    logic              unused_addr;

    assign in_win      = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off         = {bus.addr[4:2], 2'b00};
    assign wr_en       = bus.memwr & in_win;
    assign unused_addr = ^bus.addr[1:0];

    mmio_periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_en && off == OFF_TH),
        .wr_tl   (wr_en && off == OFF_TL),
        .wr_tcon (wr_en && off == OFF_TCON),
        .wdata   (bus.wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds    <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_en && off == OFF_LED)  leds <= bus.wdata[LED_W-1:0];
            if (wr_en && off == OFF_DIGI) digi <= bus.wdata[DIGI_W-1:0];
        end
    end

    // Unmapped slots inside the window still claim the access and return zero.
    always_comb begin
        bus.rdata = '0;
        bus.hit   = 1'b0;
        if (bus.memread && in_win) begin
            bus.hit = 1'b1;
            case (off)
                OFF_TH:      bus.rdata = th;
                OFF_TL:      bus.rdata = tl;
                OFF_TCON:    bus.rdata = 32'(tcon);
                OFF_LED:     bus.rdata = 32'(leds);
                OFF_DIGI:    bus.rdata = 32'(digi);
                OFF_SYSTICK: bus.rdata = systick;
                default:     bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph: reset, LED/DIGI, timer reload, irq race, collisions, async reset.
module tb_mmio_periph;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    mmio_periph_if bus();

    mmio_periph dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .leds  (leds),
        .digi  (digi),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.memwr = 1'b1; bus.memread = 1'b0;
        step();
        bus.memwr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.addr = a; bus.memread = 1'b1;
        #1;
        d = bus.rdata; h = bus.hit;
        bus.memread = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        bus.addr = '0; bus.wdata = '0; bus.memwr = 1'b0; bus.memread = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.addr    = 32'h4000_0000 | 32'($urandom_range(0, 7) << 2);
            bus.wdata   = $urandom;
            bus.memwr   = 1'($urandom_range(0, 1));
            bus.memread = 1'($urandom_range(0, 1));
            step();
        end
        bus.memwr = 1'b0;
        checks++;
        if ({leds, digi, irq} !== 21'b0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {leds, digi, irq});
        end
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_tl got %h exp 0", d); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(A_TICK, d, h);
            checks++;
            if (d !== 32'(i) || h !== 1'b1) begin
                errors++; $display("FAIL systick_%0d got %h/%b exp %h/1", i, d, h, 32'(i));
            end
            step();
        end
        bus.addr = A_LED; bus.memread = 1'b0;
        #1;
        checks++;
        if (bus.hit !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL noread_idle got %h/%b exp 0/0", bus.rdata, bus.hit);
        end
    endtask

    task automatic test_led_digi();
        logic [31:0] d;
        logic [31:0] s0;
        logic        h;
        wr(A_LED, 32'h1234_565A);
        checks++;
        if (leds !== 8'h5A) begin errors++; $display("FAIL led_out got %h exp 5a", leds); end
        wr(A_DIGI, 32'h0000_0ABC);
        checks++;
        if (digi !== 12'hABC) begin errors++; $display("FAIL digi_out got %h exp abc", digi); end
        rd(A_LED, d, h);
        checks++;
        if (d !== 32'h5A || h !== 1'b1) begin errors++; $display("FAIL led_rd got %h/%b exp 5a/1", d, h); end
        rd(A_DIGI, d, h);
        checks++;
        if (d !== 32'hABC || h !== 1'b1) begin errors++; $display("FAIL digi_rd got %h/%b exp abc/1", d, h); end
        wr(32'h4000_002C, 32'h11);
        wr(32'h4000_0030, 32'h22);
        checks++;
        if (leds !== 8'h5A || digi !== 12'hABC) begin
            errors++; $display("FAIL outwin_wr got %h/%h exp 5a/abc", leds, digi);
        end
        rd(32'h4000_0020, d, h);
        checks++;
        if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL outwin_rd got %h/%b exp 0/0", d, h); end
        rd(32'h4000_0018, d, h);
        checks++;
        if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL unmapped_rd got %h/%b exp 0/1", d, h); end
        bus.addr = A_LED; bus.wdata = 32'h33; bus.memwr = 1'b1; bus.memread = 1'b1;
        #1;
        checks++;
        if (bus.rdata !== 32'h5A) begin errors++; $display("FAIL rw_same got %h exp 5a", bus.rdata); end
        step();
        bus.memwr = 1'b0; bus.memread = 1'b0;
        rd(32'h4000_000E, d, h);
        checks++;
        if (d !== 32'h33) begin errors++; $display("FAIL rw_after got %h exp 33", d); end
        rd(A_TICK, s0, h);
        wr(A_TICK, 32'h0);
        rd(A_TICK, d, h);
        checks++;
        if (d !== s0 + 32'd1) begin errors++; $display("FAIL tick_ro got %h exp %h", d, s0 + 32'd1); end
    endtask

    task automatic test_timer_reload();
        logic [31:0] d;
        logic [31:0] t;
        logic        h;
        logic [31:0] exp_tl [3];
        exp_tl = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h3);
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL reload_start got %h exp fffffffd", d); end
        for (int i = 0; i < 6; i++) begin
            step();
            rd(A_TL, d, h);
            rd(A_TCON, t, h);
            checks++;
            if (d !== exp_tl[i % 3] || t !== (i < 2 ? 32'h3 : 32'h7) || irq !== (i >= 2)) begin
                errors++;
                $display("FAIL reload_%0d got tl %h tcon %h irq %b exp tl %h tcon %h irq %b",
                         i, d, t, irq, exp_tl[i % 3], (i < 2 ? 32'h3 : 32'h7), (i >= 2));
            end
        end
    endtask

    task automatic test_irq_race();
        logic [31:0] d;
        logic [31:0] t;
        logic        h;
        wr(A_TCON, 32'h3);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
        step();
        wr(A_TCON, 32'h3);
        rd(A_TCON, t, h);
        rd(A_TL, d, h);
        checks++;
        if (t !== 32'h7 || irq !== 1'b1 || d !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL irq_race got tcon %h irq %b tl %h exp 7 1 fffffffd", t, irq, d);
        end
        wr(A_TCON, 32'h3);
        rd(A_TCON, t, h);
        checks++;
        if (t !== 32'h3 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_late_clear got tcon %h irq %b exp 3 0", t, irq);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic        h;
        wr(A_TL, 32'h10);
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL tl_wr_wins got %h exp 10", d); end
        step();
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'h11) begin errors++; $display("FAIL tl_inc_after got %h exp 11", d); end
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TH, 32'h100);
        step();
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL th_new_reload got %h exp 100", d); end
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TH, 32'h200);
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL th_old_reload got %h exp 100", d); end
        rd(A_TH, d, h);
        checks++;
        if (d !== 32'h200) begin errors++; $display("FAIL th_rd got %h exp 200", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic [31:0] t;
        logic        h;
        wr(A_TL, 32'h1234);
        rd(A_TL, d, h);
        checks++;
        if (d !== 32'h1234 || irq !== 1'b1) begin
            errors++; $display("FAIL pre_reset got tl %h irq %b exp 1234 1", d, irq);
        end
        #1;
        reset = 1'b0;
        #1;
        rd(A_TL, d, h);
        rd(A_TCON, t, h);
        checks++;
        if (d !== 32'h0 || t !== 32'h0 || irq !== 1'b0 || leds !== 8'h0 || digi !== 12'h0) begin
            errors++;
            $display("FAIL async_reset got tl %h tcon %h irq %b leds %h digi %h exp all 0",
                     d, t, irq, leds, digi);
        end
        step();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_led_digi();
        test_timer_reload();
        test_irq_race();
        test_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
